// File: rtl/lfsr_rand_pkg.sv
// Shared definitions for the multi-channel LFSR noise source: FSM encoding,
// default Fibonacci tap masks, the recovery seed and a bit-reverse helper.
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [23:0] TAP_M0   = 24'hC20001;
  localparam logic [23:0] TAP_M1   = 24'hC00081;
  localparam logic [23:0] TAP_M2   = 24'hB00001;
  localparam logic [23:0] TAP_M3   = 24'hA00801;
  localparam logic [23:0] DEF_SEED = 24'h000001;

  // Widest output slice bit_rev can handle; callers zero-extend into it.
  localparam int BR_MAX_W = 64;

  // Reverses the low n bits of v (bit 0 <-> bit n-1); upper result bits are 0.
  function automatic logic [BR_MAX_W-1:0] bit_rev(input logic [BR_MAX_W-1:0] v,
                                                  input int n);
    logic [BR_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BR_MAX_W; i++) begin
      if (i < n) r[n-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_rand_chan.sv
// One LFSR channel: W-bit Fibonacci shift register with seed load, step,
// tap-set selection and an optionally bit-reversed output slice.
module lfsr_rand_chan
  import lfsr_rand_pkg::*;
#(
  parameter int             W     = 24,
  parameter int             OUT_W = 11,
  parameter logic [W-1:0]   TAP0  = W'(TAP_M0),
  parameter logic [W-1:0]   TAP1  = W'(TAP_M1),
  parameter logic [W-1:0]   TAP2  = W'(TAP_M2),
  parameter logic [W-1:0]   TAP3  = W'(TAP_M3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [W-1:0]     i_seed,
  input  logic [1:0]       i_mode,
  input  logic             i_rev,
  output logic [OUT_W-1:0] o_out
);

  logic [W-1:0] r_sr;
  logic [W-1:0] w_tap;
  logic [W-1:0] w_sr_next;
  logic         w_fb;

  always_comb begin
    w_tap = TAP0;
    case (i_mode)
      2'd0:    w_tap = TAP0;
      2'd1:    w_tap = TAP1;
      2'd2:    w_tap = TAP2;
      default: w_tap = TAP3;
    endcase
  end

  assign w_fb = ^(r_sr & w_tap);

  // A seed load always overrides a step issued in the same cycle.
  always_comb begin
    w_sr_next = r_sr;
    if (i_load) begin
      w_sr_next = i_seed;
    end else if (i_step) begin
      w_sr_next = {w_fb, r_sr[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_next;
    end
  end

  assign o_out = i_rev ? OUT_W'(bit_rev(BR_MAX_W'(r_sr[OUT_W-1:0]), OUT_W))
                       : r_sr[OUT_W-1:0];

endmodule

// File: rtl/lfsr_rand_gen.sv
// Multi-channel LFSR noise/dither source with valid/ready output, pause control
// and word counter. Optional all-zero seed recovery: LFSR_LOCKUP_RECOVER_EN.
module lfsr_rand_gen
  import lfsr_rand_pkg::*;
#(
  parameter int           W        = 24,
  parameter int           OUT_W    = 11,
  parameter int           NCH      = 2,
  parameter logic [W-1:0] TAP0     = W'(TAP_M0),
  parameter logic [W-1:0] TAP1     = W'(TAP_M1),
  parameter logic [W-1:0] TAP2     = W'(TAP_M2),
  parameter logic [W-1:0] TAP3     = W'(TAP_M3),
  parameter int           CNT_W    = 16,
  parameter logic [W-1:0] DEF_SEED = W'(lfsr_rand_pkg::DEF_SEED)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 seed_vld,
  output logic                 seed_rdy,
  input  logic [NCH*W-1:0]     seed,
  input  logic [1:0]           mode,
  input  logic                 rev,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [NCH*OUT_W-1:0] out,
  output logic [CNT_W-1:0]     cnt,
  output logic                 lock_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_mode;
  logic             r_rev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_seed_acc;
  logic             w_accept;
  logic             w_step;
  logic [NCH*W-1:0] w_seed_eff;

  genvar gi;

  assign seed_rdy   = rst;
  assign w_seed_acc = seed_vld & seed_rdy;
  assign out_vld    = (r_state == RUN);
  assign w_accept   = out_vld & out_rdy & en;
  // A coincident seed load consumes the current word without stepping.
  assign w_step     = w_accept & ~w_seed_acc;
  assign cnt        = r_cnt;

  always_comb begin
    w_state_next = r_state;
    if (w_seed_acc) begin
      w_state_next = en ? RUN : PAUSE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        RUN:     if (!en) w_state_next = PAUSE;
        PAUSE:   if (en) w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mode  <= 2'd0;
      r_rev   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_seed_acc) begin
        r_mode <= mode;
        r_rev  <= rev;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic [NCH-1:0] w_zero;
  logic           r_lock_err;

  // An all-zero channel seed would lock that LFSR; substitute a per-channel seed.
  for (gi = 0; gi < NCH; gi++) begin : g_recover
    assign w_zero[gi] = (seed[gi*W +: W] == '0);
    assign w_seed_eff[gi*W +: W] = w_zero[gi] ? (DEF_SEED ^ W'(gi))
                                              : seed[gi*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lock_err <= 1'b0;
    end else if (w_seed_acc && (|w_zero)) begin
      r_lock_err <= 1'b1;
    end
  end

  assign lock_err = r_lock_err;
`else
  assign w_seed_eff = seed;
  assign lock_err   = 1'b0;
`endif

  for (gi = 0; gi < NCH; gi++) begin : g_chan
    lfsr_rand_chan #(
      .W     (W),
      .OUT_W (OUT_W),
      .TAP0  (TAP0),
      .TAP1  (TAP1),
      .TAP2  (TAP2),
      .TAP3  (TAP3)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_seed_acc),
      .i_step (w_step),
      .i_seed (w_seed_eff[gi*W +: W]),
      .i_mode (r_mode),
      .i_rev  (r_rev),
      .o_out  (out[gi*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen: vector table, hand sequences and a
// word scoreboard driven by an independent cycle model.
`timescale 1ns/1ps
module tb_lfsr_rand_gen;

  localparam int           W      = 24;
  localparam int           OUT_W  = 11;
  localparam int           NCH    = 2;
  localparam int           CNT_W  = 16;
  localparam logic [W-1:0] TB_DEF = 24'h000002;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en = 1'b0;
  logic                 seed_vld = 1'b0;
  logic                 seed_rdy;
  logic [NCH*W-1:0]     seed = '0;
  logic [1:0]           mode = 2'd0;
  logic                 rev = 1'b0;
  logic                 out_vld;
  logic                 out_rdy = 1'b0;
  logic [NCH*OUT_W-1:0] out;
  logic [CNT_W-1:0]     cnt;
  logic                 lock_err;

  always #5 clk = ~clk;

  lfsr_rand_gen #(
    .W(W), .OUT_W(OUT_W), .NCH(NCH), .CNT_W(CNT_W), .DEF_SEED(TB_DEF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seed_vld(seed_vld), .seed_rdy(seed_rdy),
    .seed(seed), .mode(mode), .rev(rev), .out_vld(out_vld), .out_rdy(out_rdy),
    .out(out), .cnt(cnt), .lock_err(lock_err)
  );

  typedef struct {
    bit          r, e, sv;
    logic [23:0] s0, s1;
    logic [1:0]  md;
    bit          rv, ordy;
    int          reps;
    bit          chk, e_vld;
    logic [15:0] e_cnt;
    logic [10:0] e_o0, e_o1;
  } vec_t;

  // Reference model state
  logic [W-1:0]         m_sr [NCH];
  logic [1:0]           m_mode;
  logic                 m_rev;
  logic [CNT_W-1:0]     m_cnt;
  int                   m_st;   // 0 idle, 1 run, 2 pause
  logic                 m_lock;
  logic [NCH*OUT_W-1:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] tap_of(input logic [1:0] m);
    case (m)
      2'd0:    return 24'hC20001;
      2'd1:    return 24'hC00081;
      2'd2:    return 24'hB00001;
      default: return 24'hA00801;
    endcase
  endfunction

  function automatic logic [NCH*OUT_W-1:0] m_out();
    logic [NCH*OUT_W-1:0] o;
    o = '0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < OUT_W; i++)
        o[c*OUT_W + i] = m_rev ? m_sr[c][OUT_W-1-i] : m_sr[c][i];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit sv, input logic [W-1:0] s0,
                       input logic [W-1:0] s1, input logic [1:0] md, input bit rv,
                       input bit ordy);
    rst = r; en = e; seed_vld = sv; seed = {s1, s0};
    mode = md; rev = rv; out_rdy = ordy;
  endtask

  // Scoreboard pop, model update, one clock, then compare all outputs.
  task automatic tick();
    logic [NCH*OUT_W-1:0] w;
    logic [W-1:0]         s;
    bit                   acc;
    if (out_vld === 1'b1 && out_rdy && en) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty: got word %0h expected none pending", out);
      end else begin
        w = exp_q.pop_front();
        check("sb_word", out, w);
      end
    end
    if (!rst) begin
      m_st = 0; m_mode = 0; m_rev = 0; m_cnt = 0; m_lock = 0;
      for (int c = 0; c < NCH; c++) m_sr[c] = '0;
      exp_q.delete();
    end else begin
      acc = (m_st == 1) && out_rdy && en;
      if (seed_vld) begin
        for (int c = 0; c < NCH; c++) begin
          s = seed[c*W +: W];
`ifdef LFSR_LOCKUP_RECOVER_EN
          if (s == '0) begin
            s = TB_DEF ^ W'(c);
            m_lock = 1'b1;
          end
`endif
          m_sr[c] = s;
        end
        m_mode = mode; m_rev = rev; m_cnt = 0;
        m_st = en ? 1 : 2;
        exp_q.delete();
        exp_q.push_back(m_out());
      end else begin
        if (acc) begin
          for (int c = 0; c < NCH; c++)
            m_sr[c] = {^(m_sr[c] & tap_of(m_mode)), m_sr[c][W-1:1]};
          m_cnt++;
          exp_q.push_back(m_out());
        end
        if (m_st == 1 && !en) m_st = 2;
        else if (m_st == 2 && en) m_st = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_vld", out_vld, (m_st == 1));
    check("cnt", cnt, m_cnt);
    check("out", out, m_out());
    check("lock_err", lock_err, m_lock);
    check("seed_rdy", seed_rdy, rst);
  endtask

  vec_t tbl [10];

  initial begin
    logic [W-1:0] s0, s1;

    tbl[0] = '{0,0,0, 24'h0,      24'h0,      2'd0,0,0, 2,1, 0,16'd0, 11'h000,11'h000};
    tbl[1] = '{1,0,0, 24'h0,      24'h0,      2'd0,0,1,10,1, 0,16'd0, 11'h000,11'h000};
    tbl[2] = '{1,1,1, 24'h000001, 24'h000ABC, 2'd0,0,1, 1,1, 1,16'd0, 11'h001,11'h2BC};
    tbl[3] = '{1,1,0, 24'h0,      24'h0,      2'd0,0,1, 1,1, 1,16'd1, 11'h000,11'h55E};
    tbl[4] = '{1,1,0, 24'h0,      24'h0,      2'd0,0,1, 1,1, 1,16'd2, 11'h000,11'h2AF};
    tbl[5] = '{1,1,1, 24'hFFFFFF, 24'h000001, 2'd0,1,1, 1,1, 1,16'd0, 11'h7FF,11'h400};
    tbl[6] = '{1,1,0, 24'h0,      24'h0,      2'd0,0,1, 1,1, 1,16'd1, 11'h7FF,11'h000};
    tbl[7] = '{1,0,1, 24'hFFFFFF, 24'h123456, 2'd0,0,1, 1,1, 0,16'd0, 11'h7FF,11'h456};
    tbl[8] = '{1,1,0, 24'h0,      24'h0,      2'd0,0,1, 1,1, 1,16'd0, 11'h7FF,11'h456};
    tbl[9] = '{1,1,0, 24'h0,      24'h0,      2'd0,0,1, 1,1, 1,16'd1, 11'h7FF,11'h22B};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        drive(tbl[i].r, tbl[i].e, tbl[i].sv, tbl[i].s0, tbl[i].s1,
              tbl[i].md, tbl[i].rv, tbl[i].ordy);
        tick();
        if (tbl[i].chk) begin
          check("tbl_vld", out_vld, tbl[i].e_vld);
          check("tbl_cnt", cnt, tbl[i].e_cnt);
          check("tbl_o0", out[OUT_W-1:0], tbl[i].e_o0);
          check("tbl_o1", out[2*OUT_W-1:OUT_W], tbl[i].e_o1);
        end
      end
    end

    // Consumer stall, then pause with out_rdy high: nothing consumed.
    for (int k = 0; k < 5; k++) begin drive(1,1,0,0,0,0,0,0); tick(); end
    for (int k = 0; k < 3; k++) begin drive(1,0,0,0,0,0,0,1); tick(); end
    check("stall_cnt", cnt, 16'd1);
    for (int k = 0; k < 4; k++) begin drive(1,1,0,0,0,0,0,1); tick(); end
    check("resume_cnt", cnt, 16'd4);

    // Every tap set, with ignored mode/rev wiggles between seed loads.
    for (int m = 0; m < 4; m++) begin
      s0 = W'($urandom) | 24'h000001;
      s1 = W'($urandom) | 24'h100000;
      drive(1,1,1,s0,s1,2'(m),m[1],1); tick();
      for (int k = 0; k < 60; k++) begin
        drive(1, $urandom_range(0,7) != 0, 0, W'($urandom), W'($urandom),
              2'($urandom), 1'($urandom), $urandom_range(0,3) != 0);
        tick();
      end
    end

    // Reset while running drops the pending word.
    drive(0,1,0,0,0,0,0,1); tick();
    check("rst_vld", out_vld, 1'b0);
    check("rst_cnt", cnt, 16'd0);
    check("rst_out", out, 22'd0);
    for (int k = 0; k < 2; k++) begin drive(1,1,0,0,0,0,0,1); tick(); end

    // All-zero seed on channel 1.
    drive(1,1,1,24'h000005,24'h000000,0,0,1); tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("lock_o1", out[2*OUT_W-1:OUT_W], 11'h003);
    check("lock_set", lock_err, 1'b1);
`else
    check("lock_o1", out[2*OUT_W-1:OUT_W], 11'h000);
    check("lock_set", lock_err, 1'b0);
`endif
    for (int k = 0; k < 20; k++) begin drive(1,1,0,0,0,0,0,1); tick(); end
`ifndef LFSR_LOCKUP_RECOVER_EN
    check("lock_stuck", out[2*OUT_W-1:OUT_W], 11'h000);
`endif
    drive(1,1,1,24'h000001,24'h000001,0,0,1); tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("lock_sticky", lock_err, 1'b1);
`else
    check("lock_sticky", lock_err, 1'b0);
`endif
    drive(0,0,0,0,0,0,0,0); tick();
    check("lock_clr", lock_err, 1'b0);

    // Counter wrap after 2^16 accepted words.
    drive(1,1,1,24'h000001,24'h000003,1,0,1); tick();
    for (int k = 0; k < 65536; k++) begin drive(1,1,0,0,0,0,0,1); tick(); end
    check("wrap_cnt", cnt, 16'd0);
    drive(1,1,0,0,0,0,0,1); tick();
    check("wrap_cnt1", cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
